demux16_router: RTL and testbench

One-to-four 16-bit demultiplexer with a holding register on every destination, the write-side counterpart of the datapath 16-bit input-select mux. A single producer (ALU write-back or an I/O store) presents a word plus a destination select. The router steers the word into one of four output slots, and each slot holds it under a valid/ack handshake until its consumer takes it. It sits between the SISC datapath and the memory-mapped output/peripheral ports.

---
 rtl/demux16_router_pkg.sv | 10 +
 rtl/demux16_router_slot.sv | 32 +++
 rtl/demux16_router.sv | 44 ++++
 tb/tb_demux16_router.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/demux16_router_pkg.sv
// sisc_defs: shared widths and slot state encoding for the demux16 router
package sisc_defs;
    localparam int WIDTH_D = 16;
    localparam int NCH_D   = 4;
    localparam int SELW_D  = 2;
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;
endpackage

// File: rtl/demux16_router_slot.sv
// demux16_slot: one-entry holding buffer with valid/ack handshake
import sisc_defs::*;
module demux16_slot #(
    parameter int WIDTH = WIDTH_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);
    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    // load wins over ack so an acked slot can be refilled in the same cycle
    always_comb begin
        state_d = load ? FULL : (ack ? EMPTY : state_q);
        data_d  = load ? d : data_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end
    assign q     = data_q;
    assign valid = (state_q == FULL);
endmodule

// File: rtl/demux16_router.sv
// demux16_router: steers one producer word into one of NCH handshaked holding slots
import sisc_defs::*;
module demux16_router #(
    parameter int WIDTH = WIDTH_D,
    parameter int NCH   = NCH_D,
    parameter int SELW  = SELW_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]     out_valid,
    input  logic [NCH-1:0]     out_ack,
    output logic [15:0]        accept_cnt
);
    logic           accept;
    logic [NCH-1:0] load;
    logic [15:0]    accept_cnt_q, accept_cnt_d;
    always_comb begin
        in_ready     = !out_valid[in_sel] || out_ack[in_sel];
        accept       = in_valid && in_ready;
        load         = {{(NCH-1){1'b0}}, accept} << in_sel;
        accept_cnt_d = accept_cnt_q + 16'(accept);
    end
    always_ff @(posedge clk) begin
        if (rst) accept_cnt_q <= '0;
        else     accept_cnt_q <= accept_cnt_d;
    end
    assign accept_cnt = accept_cnt_q;
    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux16_slot #(.WIDTH(WIDTH)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (load[k]),
            .ack   (out_ack[k]),
            .d     (in_data),
            .q     (out_data[k*WIDTH +: WIDTH]),
            .valid (out_valid[k])
        );
    end
endmodule

// File: tb/tb_demux16_router.sv
// tb_demux16_router: random and directed stimulus checked against a slot-level reference model
module tb_demux16_router;
    localparam int W = 16;
    localparam int N = 4;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic [1:0]     in_sel = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] out_data;
    logic [N-1:0]   out_valid;
    logic [N-1:0]   out_ack = '0;
    logic [15:0]    accept_cnt;
    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    logic [W-1:0] m_data [N];
    bit           m_valid [N];
    int           m_cnt = 0;

    demux16_router dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ack(out_ack), .accept_cnt(accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_valid[in_sel] || out_ack[in_sel];
    endfunction

    // Reference: each slot is a one-word mailbox; accept fills it, ack alone empties it
    always @(posedge clk) begin
        bit acc;
        acc = in_valid && m_ready();
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 1'b0;
                m_data[k]  = '0;
            end
            m_cnt = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (acc && in_sel == k) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = in_data;
                end else if (out_ack[k]) m_valid[k] = 1'b0;
            end
            if (acc) m_cnt = (m_cnt + 1) % 65536;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] ev;
            for (int k = 0; k < N; k++) ev[k] = m_valid[k];
            check("mdl_in_ready", in_ready, m_ready());
            check("mdl_out_valid", out_valid, ev);
            check("mdl_accept_cnt", accept_cnt, m_cnt);
            for (int k = 0; k < N; k++) check("mdl_out_data", out_data[k*W +: W], m_data[k]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d, input logic [N-1:0] a);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        out_ack  = a;
    endtask

    initial begin
        drive(0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_valid", out_valid, 4'b0000);
        check("rst_data", out_data, 64'h0);
        check("rst_cnt", accept_cnt, 16'h0);
        check("rst_ready", in_ready, 1'b1);
        tick();
        drive(1, 2, 16'h1234, 0);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("wr_valid", out_valid, 4'b0100);
        check("wr_slot2", out_data[2*W +: W], 16'h1234);
        tick();
        drive(0, 0, 0, 4'b0100);
        tick();
        drive(1, 1, 16'hAAAA, 0);
        tick();
        drive(1, 1, 16'h5555, 0);
        @(negedge clk);
        check("bp_ready", in_ready, 1'b0);
        tick();
        @(negedge clk);
        check("bp_slot1", out_data[1*W +: W], 16'hAAAA);
        tick();
        drive(1, 3, 16'h5555, 0);
        @(negedge clk);
        check("bp_other_ready", in_ready, 1'b1);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("bp_slot3", out_data[3*W +: W], 16'h5555);
        check("bp_valid", out_valid, 4'b1010);
        tick();
        drive(0, 0, 0, 4'b1111);
        tick();
        drive(1, 0, 16'h0001, 0);
        tick();
        drive(1, 0, 16'h0002, 4'b0001);
        @(negedge clk);
        check("sim_ready", in_ready, 1'b1);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("sim_valid", out_valid[0], 1'b1);
        check("sim_slot0", out_data[0 +: W], 16'h0002);
        check("sim_cnt", accept_cnt, 16'd5);
        tick();
        drive(0, 0, 0, 4'b1111);
        tick();
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("stray_valid", out_valid, 4'b0000);
        check("stray_cnt", accept_cnt, 16'd5);
        check("stray_data", out_data[0 +: W], 16'h0002);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'(i), 16'(16'h0010 + i), 0);
            tick();
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("str_valid", out_valid, 4'b1111);
        check("str_cnt", accept_cnt, 16'd4);
        check("str_data", out_data, 64'h0013_0012_0011_0010);
        tick();
        drive(0, 0, 0, 4'b1111);
        tick();
        drive(1, 0, 16'hBEEF, 0);
        tick();
        drive(1, 2, 16'hCAFE, 0);
        tick();
        drive(1, 1, 16'hF00D, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("mid_rst_valid", out_valid, 4'b0000);
        check("mid_rst_cnt", accept_cnt, 16'd0);
        check("mid_rst_data", out_data, 64'h0);
        tick();
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom), 4'($urandom_range(0, 15)));
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            drive(1, 2'(i), 16'(i), 4'b1111);
            tick();
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("wrap_ffff", accept_cnt, 16'hFFFF);
        tick();
        drive(1, 1, 16'h7777, 4'b1111);
        tick();
        drive(0, 0, 0, 0);
        @(negedge clk);
        check("wrap_zero", accept_cnt, 16'h0000);
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
